// File: rtl/bmp280_pkg.sv
// Shared types and constants for the BMP280 transaction sequencer.
package bmp280_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_BYTES = 4;
    localparam int unsigned RAW_W     = 20;
    localparam int unsigned CNT_W     = 32;

    typedef enum logic [3:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        CFG_REQ,
        CFG_WAIT,
        PERIOD_WAIT,
        P_REQ,
        P_WAIT,
        T_REQ,
        T_WAIT,
        PUBLISH,
        FAULT
    } state_t;

    // Byte 0 goes out first on the wire and carries the register address.
    typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] spi_bytes_t;

    localparam logic [BYTE_W-1:0] REG_ID        = 8'hD0;
    localparam logic [BYTE_W-1:0] REG_CTRL_MEAS = 8'hF4;
    localparam logic [BYTE_W-1:0] REG_CONFIG    = 8'hF5;
    localparam logic [BYTE_W-1:0] REG_PRESS_MSB = 8'hF7;
    localparam logic [BYTE_W-1:0] REG_TEMP_MSB  = 8'hFA;
    localparam logic [BYTE_W-1:0] CHIP_ID       = 8'h58;
    localparam logic [BYTE_W-1:0] READ_BIT      = 8'h80;
    localparam logic [1:0]        SPI_WORDS     = 2'b11;

    // Build a transaction payload from its four bytes in wire order.
    function automatic spi_bytes_t pack_bytes(input logic [BYTE_W-1:0] b0,
                                              input logic [BYTE_W-1:0] b1,
                                              input logic [BYTE_W-1:0] b2,
                                              input logic [BYTE_W-1:0] b3);
        spi_bytes_t r;
        r[0] = b0;
        r[1] = b1;
        r[2] = b2;
        r[3] = b3;
        return r;
    endfunction

    // MSB, LSB and the upper XLSB nibble form the 20-bit raw ADC word.
    function automatic logic [RAW_W-1:0] raw20(input spi_bytes_t rx);
        return {rx[1], rx[2], rx[3][7:4]};
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/bmp280_sequencer_if.sv
// Port bundle between the sequencer and the 4-byte SPI transaction controller.
interface bmp280_sequencer_if;
    import bmp280_pkg::*;

    logic       spi_start;
    logic [1:0] spi_data_words;
    logic       spi_tied_ss;
    spi_bytes_t spi_tx_data;
    spi_bytes_t spi_rx_data;
    logic       spi_done;

    modport master (
        output spi_start,
        output spi_data_words,
        output spi_tied_ss,
        output spi_tx_data,
        input  spi_rx_data,
        input  spi_done
    );

    modport slave (
        input  spi_start,
        input  spi_data_words,
        input  spi_tied_ss,
        input  spi_tx_data,
        output spi_rx_data,
        output spi_done
    );

endinterface

// File: rtl/bmp280_sequencer.sv
// BMP280 sequencer: chip-ID check, configuration write, then periodic P/T burst reads.
module bmp280_sequencer
    import bmp280_pkg::*;
#(
    parameter logic [CNT_W-1:0]  SAMPLE_PERIOD = 32'd1_000_000,
    parameter logic [CNT_W-1:0]  TIMEOUT       = 32'd100_000,
    parameter logic [BYTE_W-1:0] CTRL_MEAS     = 8'h27,
    parameter logic [BYTE_W-1:0] CONFIG        = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    bmp280_sequencer_if.master        spi,
    output logic [RAW_W-1:0]          raw_press,
    output logic [RAW_W-1:0]          raw_temp,
    output logic                      sample_valid,
    output logic                      id_ok,
    output logic                      error
);

    state_t            state_q, state_d;
    logic              done_q;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic              abort_q, abort_d;
    logic              start_q, start_d;
    spi_bytes_t        tx_q, tx_d;
    logic [RAW_W-1:0]  press_sh_q, press_sh_d;
    logic [RAW_W-1:0]  temp_sh_q, temp_sh_d;
    logic [RAW_W-1:0]  press_d, temp_d;
    logic              valid_d, id_ok_d, error_d;
    logic              done_rise, tmo_hit, quit;
    logic              unused_rx;

    assign spi.spi_data_words = SPI_WORDS;
    assign spi.spi_tied_ss    = 1'b1;
    assign spi.spi_start      = start_q;
    assign spi.spi_tx_data    = tx_q;

    // Byte 0 and the XLSB low nibble carry nothing we publish.
    assign unused_rx = ^{spi.spi_rx_data[0], spi.spi_rx_data[3][3:0]};

    assign done_rise = spi.spi_done & ~done_q;
    assign tmo_hit   = (tmo_q >= TIMEOUT - CNT_W'(1));
    assign quit      = abort_q | ~enable;

    // Next-state and registered-output decode.
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        tx_d       = tx_q;
        tmo_d      = sat_inc(tmo_q);
        per_d      = sat_inc(per_q);
        abort_d    = 1'b0;
        press_sh_d = press_sh_q;
        temp_sh_d  = temp_sh_q;
        press_d    = raw_press;
        temp_d     = raw_temp;
        valid_d    = 1'b0;
        id_ok_d    = id_ok;
        error_d    = error;

        case (state_q)
            IDLE: begin
                if (enable && !error) state_d = ID_REQ;
            end

            ID_REQ, CFG_REQ, P_REQ, T_REQ: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    start_d = 1'b1;
                    tmo_d   = '0;
                    case (state_q)
                        ID_REQ: begin
                            tx_d    = pack_bytes(REG_ID | READ_BIT, 8'h00, 8'h00, 8'h00);
                            state_d = ID_WAIT;
                        end
                        CFG_REQ: begin
                            tx_d    = pack_bytes(REG_CTRL_MEAS & ~READ_BIT, CTRL_MEAS,
                                                 REG_CONFIG & ~READ_BIT, CONFIG);
                            state_d = CFG_WAIT;
                        end
                        P_REQ: begin
                            tx_d    = pack_bytes(REG_PRESS_MSB | READ_BIT, 8'h00, 8'h00, 8'h00);
                            state_d = P_WAIT;
                        end
                        default: begin
                            tx_d    = pack_bytes(REG_TEMP_MSB | READ_BIT, 8'h00, 8'h00, 8'h00);
                            state_d = T_WAIT;
                        end
                    endcase
                end
            end

            ID_WAIT, CFG_WAIT, P_WAIT, T_WAIT: begin
                // A run request dropped mid-transaction is remembered until the transaction ends.
                abort_d = quit;
                if (done_rise) begin
                    if (quit) begin
                        state_d = IDLE;
                    end else begin
                        case (state_q)
                            ID_WAIT: begin
                                if (spi.spi_rx_data[1] == CHIP_ID) begin
                                    id_ok_d = 1'b1;
                                    state_d = CFG_REQ;
                                end else begin
                                    id_ok_d = 1'b0;
                                    error_d = 1'b1;
                                    state_d = FAULT;
                                end
                            end
                            CFG_WAIT: state_d = P_REQ;
                            P_WAIT: begin
                                press_sh_d = raw20(spi.spi_rx_data);
                                state_d    = T_REQ;
                            end
                            default: begin
                                temp_sh_d = raw20(spi.spi_rx_data);
                                state_d   = PUBLISH;
                            end
                        endcase
                    end
                end else if (tmo_hit) begin
                    if (quit) begin
                        state_d = IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = FAULT;
                    end
                end
            end

            PERIOD_WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (per_q >= SAMPLE_PERIOD - CNT_W'(1)) begin
                    state_d = P_REQ;
                end
            end

            PUBLISH: begin
                press_d = press_sh_q;
                temp_d  = temp_sh_q;
                valid_d = 1'b1;
                state_d = enable ? PERIOD_WAIT : IDLE;
            end

            FAULT: begin
                if (!enable) begin
                    error_d = 1'b0;
                    id_ok_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Period is measured start-to-start, so it restarts as P_REQ is entered.
        if (state_d == P_REQ && state_q != P_REQ) per_d = '0;
    end

    // State, counters and done-edge register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            tmo_q   <= '0;
            per_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= spi.spi_done;
            tmo_q   <= tmo_d;
            per_q   <= per_d;
            abort_q <= abort_d;
        end
    end

    // Registered outputs and capture shadows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q      <= 1'b0;
            tx_q         <= '0;
            press_sh_q   <= '0;
            temp_sh_q    <= '0;
            raw_press    <= '0;
            raw_temp     <= '0;
            sample_valid <= 1'b0;
            id_ok        <= 1'b0;
            error        <= 1'b0;
        end else begin
            start_q      <= start_d;
            tx_q         <= tx_d;
            press_sh_q   <= press_sh_d;
            temp_sh_q    <= temp_sh_d;
            raw_press    <= press_d;
            raw_temp     <= temp_d;
            sample_valid <= valid_d;
            id_ok        <= id_ok_d;
            error        <= error_d;
        end
    end

endmodule
